missile_flight_controller: RTL and testbench

//  Sequences one tank missile through its lifetime: launch, per-frame flight, explosion, cooldown.

---
 rtl/battle_pkg.sv | 25 ++
 rtl/missile_step.sv | 43 ++++
 rtl/missile_flight_controller.sv | 142 ++++++++++++++
 tb/tb_missile_flight_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared types and screen geometry for the tank battle game.
package battle_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    EXPLODE,
    COOLDOWN
  } missile_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/missile_step.sv
// Moves a point by `step` pixels along `dir` and flags a missile square that would leave the screen.
module missile_step #(
  parameter int MISSILE_SIZE = 8,
  parameter int SCREEN_W     = battle_pkg::SCREEN_W,
  parameter int SCREEN_H     = battle_pkg::SCREEN_H,
  parameter int STEP_W       = 6
) (
  input  logic signed [11:0]       pos_x,
  input  logic signed [11:0]       pos_y,
  input  logic        [1:0]        dir,
  input  logic        [STEP_W-1:0] step,
  output logic signed [11:0]       next_x,
  output logic signed [11:0]       next_y,
  output logic                     out_of_bounds
);
  import battle_pkg::*;

  localparam logic signed [12:0] MAX_X = 13'(SCREEN_W - MISSILE_SIZE);
  localparam logic signed [12:0] MAX_Y = 13'(SCREEN_H - MISSILE_SIZE);

  // One spare bit so a step past the 12-bit range still reads as off screen.
  logic signed [12:0] nx;
  logic signed [12:0] ny;
  logic signed [12:0] step_s;

  assign step_s = 13'(step);

  always_comb begin
    nx = {pos_x[11], pos_x};
    ny = {pos_y[11], pos_y};
    case (dir_t'(dir))
      UP:    ny = ny - step_s;
      DOWN:  ny = ny + step_s;
      LEFT:  nx = nx - step_s;
      RIGHT: nx = nx + step_s;
    endcase
  end

  assign next_x        = nx[11:0];
  assign next_y        = ny[11:0];
  assign out_of_bounds = nx[12] | ny[12] | (nx > MAX_X) | (ny > MAX_Y);

endmodule

// File: rtl/missile_flight_controller.sv
// Sequences one tank missile: launch, per-frame flight, explosion, cooldown.
module missile_flight_controller #(
  parameter int MISSILE_SIZE    = 8,
  parameter int TANK_SIZE       = 32,
  parameter int SPEED           = 4,
  parameter int SCREEN_W        = battle_pkg::SCREEN_W,
  parameter int SCREEN_H        = battle_pkg::SCREEN_H,
  parameter int EXPLODE_FRAMES  = 8,
  parameter int COOLDOWN_FRAMES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        fireReq,
  input  logic [10:0] tankTopLeftX,
  input  logic [10:0] tankTopLeftY,
  input  logic [1:0]  tankDir,
  input  logic        collision,
  output logic        fireAck,
  output logic        missileActive,
  output logic        explodeActive,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  dir
);
  import battle_pkg::*;

  localparam int CENTRE_OFF = (TANK_SIZE - MISSILE_SIZE) / 2;
  // From the tank centre line, the facing edge is this far away in every direction.
  localparam int LAUNCH_OFF = (TANK_SIZE + MISSILE_SIZE) / 2;
  localparam int STEP_W     = $clog2(max2(LAUNCH_OFF, SPEED) + 1);
  localparam int CNT_W      = $clog2(max2(EXPLODE_FRAMES, COOLDOWN_FRAMES) + 1);

  missile_state_t     state;
  logic [CNT_W-1:0]   frame_cnt;
  logic signed [11:0] pos_x;
  logic signed [11:0] pos_y;
  dir_t               dir_q;

  logic signed [11:0] ctr_x, ctr_y;
  logic signed [11:0] launch_x, launch_y, fly_x, fly_y;
  logic               launch_oob, fly_oob;

  assign ctr_x = 12'({1'b0, tankTopLeftX} + 12'(CENTRE_OFF));
  assign ctr_y = 12'({1'b0, tankTopLeftY} + 12'(CENTRE_OFF));

  missile_step #(
    .MISSILE_SIZE(MISSILE_SIZE),
    .SCREEN_W    (SCREEN_W),
    .SCREEN_H    (SCREEN_H),
    .STEP_W      (STEP_W)
  ) u_launch (
    .pos_x        (ctr_x),
    .pos_y        (ctr_y),
    .dir          (tankDir),
    .step         (STEP_W'(LAUNCH_OFF)),
    .next_x       (launch_x),
    .next_y       (launch_y),
    .out_of_bounds(launch_oob)
  );

  missile_step #(
    .MISSILE_SIZE(MISSILE_SIZE),
    .SCREEN_W    (SCREEN_W),
    .SCREEN_H    (SCREEN_H),
    .STEP_W      (STEP_W)
  ) u_fly (
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .dir          (dir_q),
    .step         (STEP_W'(SPEED)),
    .next_x       (fly_x),
    .next_y       (fly_y),
    .out_of_bounds(fly_oob)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      pos_x         <= '0;
      pos_y         <= '0;
      dir_q         <= UP;
      fireAck       <= 1'b0;
      missileActive <= 1'b0;
      explodeActive <= 1'b0;
    end else begin
      fireAck <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fireReq && !launch_oob) begin
            state         <= FLYING;
            frame_cnt     <= '0;
            pos_x         <= launch_x;
            pos_y         <= launch_y;
            dir_q         <= dir_t'(tankDir);
            fireAck       <= 1'b1;
            missileActive <= 1'b1;
          end
        end
        FLYING: begin
          // A hit outranks the frame move; leaving the screen keeps the last in-bounds spot.
          if (collision || (startOfFrame && fly_oob)) begin
            state         <= EXPLODE;
            frame_cnt     <= '0;
            missileActive <= 1'b0;
            explodeActive <= 1'b1;
          end else if (startOfFrame) begin
            pos_x <= fly_x;
            pos_y <= fly_y;
          end
        end
        EXPLODE: begin
          if (startOfFrame) begin
            if (frame_cnt == CNT_W'(EXPLODE_FRAMES - 1)) begin
              state         <= COOLDOWN;
              frame_cnt     <= '0;
              explodeActive <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        COOLDOWN: begin
          if (startOfFrame) begin
            if (frame_cnt == CNT_W'(COOLDOWN_FRAMES - 1)) begin
              state     <= IDLE;
              frame_cnt <= '0;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign topLeftX = pos_x[10:0];
  assign topLeftY = pos_y[10:0];
  assign dir      = dir_q;

endmodule

// File: tb/tb_missile_flight_controller.sv
// Self-checking bench: per-cycle comparison against a frame-level missile model, plus directed scenarios.
module tb_missile_flight_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic        fireReq;
  logic [10:0] tankTopLeftX;
  logic [10:0] tankTopLeftY;
  logic [1:0]  tankDir;
  logic        collision;
  logic        fireAck;
  logic        missileActive;
  logic        explodeActive;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [1:0]  dir;

  missile_flight_controller dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .fireReq      (fireReq),
    .tankTopLeftX (tankTopLeftX),
    .tankTopLeftY (tankTopLeftY),
    .tankDir      (tankDir),
    .collision    (collision),
    .fireAck      (fireAck),
    .missileActive(missileActive),
    .explodeActive(explodeActive),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .dir          (dir)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: missile life expressed as phases and frames remaining.
  typedef enum {M_IDLE, M_FLY, M_BOOM, M_COOL} mphase_t;
  mphase_t m_phase;
  int      m_x, m_y, m_dir, m_left;
  bit      m_ack, m_act, m_exp;

  function automatic bit on_screen(input int x, input int y);
    return (x >= 0) && (y >= 0) && (x + 8 <= 640) && (y + 8 <= 480);
  endfunction

  function automatic void launch_point(input int tx, input int ty, input int d,
                                       output int lx, output int ly);
    case (d)
      0:       begin lx = tx + 12; ly = ty - 8;  end
      1:       begin lx = tx + 32; ly = ty + 12; end
      2:       begin lx = tx + 12; ly = ty + 32; end
      default: begin lx = tx - 8;  ly = ty + 12; end
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int lx, ly, nx, ny;
    if (reset) begin
      m_phase <= M_IDLE;
      m_x <= 0; m_y <= 0; m_dir <= 0; m_left <= 0;
      m_ack <= 0; m_act <= 0; m_exp <= 0;
    end else begin
      m_ack <= 0;
      case (m_phase)
        M_IDLE: if (fireReq) begin
          launch_point(int'(tankTopLeftX), int'(tankTopLeftY), int'(tankDir), lx, ly);
          if (on_screen(lx, ly)) begin
            m_phase <= M_FLY; m_ack <= 1; m_act <= 1;
            m_x <= lx; m_y <= ly; m_dir <= int'(tankDir);
          end
        end
        M_FLY: if (collision) begin
          m_phase <= M_BOOM; m_act <= 0; m_exp <= 1; m_left <= 8;
        end else if (startOfFrame) begin
          nx = m_x + ((m_dir == 1) ? 4 : (m_dir == 3) ? -4 : 0);
          ny = m_y + ((m_dir == 2) ? 4 : (m_dir == 0) ? -4 : 0);
          if (on_screen(nx, ny)) begin
            m_x <= nx; m_y <= ny;
          end else begin
            m_phase <= M_BOOM; m_act <= 0; m_exp <= 1; m_left <= 8;
          end
        end
        M_BOOM: if (startOfFrame) begin
          if (m_left == 1) begin
            m_phase <= M_COOL; m_exp <= 0; m_left <= 16;
          end else m_left <= m_left - 1;
        end
        M_COOL: if (startOfFrame) begin
          if (m_left == 1) m_phase <= M_IDLE;
          else m_left <= m_left - 1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("fireAck",       int'(fireAck),       int'(m_ack));
    check("missileActive", int'(missileActive), int'(m_act));
    check("explodeActive", int'(explodeActive), int'(m_exp));
    check("topLeftX",      int'(topLeftX),      m_x);
    check("topLeftY",      int'(topLeftY),      m_y);
    check("dir",           int'(dir),           m_dir);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic fire(input int x, input int y, input int d);
    tankTopLeftX = 11'(x);
    tankTopLeftY = 11'(y);
    tankDir      = 2'(d);
    fireReq      = 1'b1;
    tick();
    fireReq      = 1'b0;
  endtask

  task automatic hit();
    collision = 1'b1;
    tick();
    collision = 1'b0;
  endtask

  initial begin
    int  nf;
    bit  seen;
    reset = 1'b1; startOfFrame = 1'b0; fireReq = 1'b0; collision = 1'b0;
    tankTopLeftX = '0; tankTopLeftY = '0; tankDir = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ack", int'(fireAck), 0);
    check("rst_act", int'(missileActive), 0);
    check("rst_exp", int'(explodeActive), 0);
    check("rst_xy",  int'({topLeftX, topLeftY}), 0);
    reset = 1'b0;
    tick();

    // Launch to the right, then three frames of flight.
    fire(100, 200, 1);
    check("t1_ack", int'(fireAck), 1);
    check("t1_act", int'(missileActive), 1);
    check("t1_x", int'(topLeftX), 132);
    check("t1_y", int'(topLeftY), 212);
    check("t1_dir", int'(dir), 1);
    tick();
    check("t1_ack_once", int'(fireAck), 0);
    frames(3);
    check("t1_x3", int'(topLeftX), 144);
    check("t1_y3", int'(topLeftY), 212);
    hit();
    check("t1_exp", int'(explodeActive), 1);
    check("t1_hold_x", int'(topLeftX), 144);
    frames(7);
    check("t1_exp7", int'(explodeActive), 1);
    frames(1);
    check("t1_exp8", int'(explodeActive), 0);
    frames(16);

    // Left edge: x=4 -> 0 is still on screen; the following step explodes at 0.
    fire(12, 88, 3);
    check("t2_x", int'(topLeftX), 4);
    check("t2_y", int'(topLeftY), 100);
    frames(1);
    check("t2_x0", int'(topLeftX), 0);
    check("t2_act", int'(missileActive), 1);
    frames(1);
    check("t2_hold", int'(topLeftX), 0);
    check("t2_exp", int'(explodeActive), 1);
    frames(24);

    // Launch point off the top of the screen.
    fire(0, 0, 0);
    check("t3_ack", int'(fireAck), 0);
    check("t3_act", int'(missileActive), 0);

    // Collision and frame pulse together.
    fire(268, 288, 1);
    check("t4_x", int'(topLeftX), 300);
    check("t4_y", int'(topLeftY), 300);
    collision = 1'b1; startOfFrame = 1'b1;
    tick();
    collision = 1'b0; startOfFrame = 1'b0;
    check("t4_hold_x", int'(topLeftX), 300);
    check("t4_hold_y", int'(topLeftY), 300);
    check("t4_exp", int'(explodeActive), 1);
    frames(24);

    // Held fire request: next ack only after the full explosion and cooldown.
    tankTopLeftX = 11'd300; tankTopLeftY = 11'd200; tankDir = 2'd2;
    fireReq = 1'b1;
    tick();
    check("t5_ack", int'(fireAck), 1);
    check("t5_y", int'(topLeftY), 232);
    hit();
    nf = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      frames(1);
      nf++;
      if (fireAck) seen = 1;
    end
    check("t5_reack", int'(seen), 1);
    check("t5_gap_frames", nf, 24);
    fireReq = 1'b0;
    tick();
    check("t5_ack_once", int'(fireAck), 0);
    hit();
    frames(24);

    // Asynchronous reset mid-flight, then a fresh launch.
    fire(300, 200, 1);
    frames(1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_ack", int'(fireAck), 0);
    check("t6_act", int'(missileActive), 0);
    check("t6_x", int'(topLeftX), 0);
    check("t6_dir", int'(dir), 0);
    tick();
    reset = 1'b0;
    tick();
    fire(50, 50, 2);
    check("t6_refire", int'(fireAck), 1);
    check("t6_rx", int'(topLeftX), 62);
    check("t6_ry", int'(topLeftY), 82);
    hit();
    frames(24);

    for (int i = 0; i < 3000; i++) begin
      fireReq      = ($urandom % 4) == 0;
      startOfFrame = ($urandom % 6) == 0;
      collision    = ($urandom % 50) == 0;
      tankTopLeftX = 11'($urandom_range(0, 700));
      tankTopLeftY = 11'($urandom_range(0, 520));
      tankDir      = 2'($urandom % 4);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
